// File: rtl/control_sequencer.sv
// control_sequencer
//
// Hardwired control unit for CPU_Datapath. Steps through fetch (T0-T2) and an
// opcode-dependent execute sequence (T3-T7), driving every datapath strobe plus
// ALUSelection from the registered state and IR[31:27].
//
// Build option: define SEQ_MULDIV_EN to compile in the mul/div sequence. Without
// it, mul/div opcodes decode as nop and HIin, LOin, ZHighout stay 0.
//
// Ports:
//   clk           system clock, rising edge
//   clr           asynchronous active-low reset
//   run           level; start/continue fetching (sampled in IDLE and last step)
//   IR            instruction register (opcode in IR[31:27])
//   CON_FF_Out    branch condition from datapath
//   <strobes>     1-bit datapath control strobes
//   ALUSelection  5-bit ALU operation select
//   halted        high in HALT
//   step          current state code (debug): 0 IDLE, 1-8 T0-T7, 9 HALT

module control_sequencer #(
   parameter logic [4:0] ADD_SEL = 5'b00011
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        run,
   input  logic [31:0] IR,
   input  logic        CON_FF_Out,
   output logic        PCout,
   output logic        MARin,
   output logic        IncPC,
   output logic        Zin,
   output logic        ZLowout,
   output logic        ZHighout,
   output logic        PCin,
   output logic        MDRread,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        Yin,
   output logic        Cout,
   output logic        HIin,
   output logic        LOin,
   output logic        HIout,
   output logic        LOout,
   output logic        InPortout,
   output logic        OPin,
   output logic        CON_FF_In,
   output logic        wren,
   output logic [4:0]  ALUSelection,
   output logic        halted,
   output logic [3:0]  step
);

   localparam logic [3:0] StIdle = 4'd0;
   localparam logic [3:0] StT0   = 4'd1;
   localparam logic [3:0] StT1   = 4'd2;
   localparam logic [3:0] StT2   = 4'd3;
   localparam logic [3:0] StT3   = 4'd4;
   localparam logic [3:0] StT4   = 4'd5;
   localparam logic [3:0] StT5   = 4'd6;
   localparam logic [3:0] StT6   = 4'd7;
   localparam logic [3:0] StT7   = 4'd8;
   localparam logic [3:0] StHalt = 4'd9;

   // Instruction classes: opcodes sharing one execute sequence.
   localparam logic [3:0] ClNop    = 4'd0;
   localparam logic [3:0] ClAlu    = 4'd1;
   localparam logic [3:0] ClImm    = 4'd2;
   localparam logic [3:0] ClUnary  = 4'd3;
   localparam logic [3:0] ClLd     = 4'd4;
   localparam logic [3:0] ClLdi    = 4'd5;
   localparam logic [3:0] ClSt     = 4'd6;
   localparam logic [3:0] ClMulDiv = 4'd7;
   localparam logic [3:0] ClBrx    = 4'd8;
   localparam logic [3:0] ClJr     = 4'd9;
   localparam logic [3:0] ClIn     = 4'd10;
   localparam logic [3:0] ClOut    = 4'd11;
   localparam logic [3:0] ClMfhi   = 4'd12;
   localparam logic [3:0] ClMflo   = 4'd13;
   localparam logic [3:0] ClHalt   = 4'd14;

   logic [3:0] state_q, state_d;
   logic [4:0] opcode;
   logic [3:0] cls;
   logic [3:0] last_step;
   logic [4:0] imm_sel;
   logic       unused_ir;

   assign opcode    = IR[31:27];
   assign unused_ir = ^IR[26:0];

   always_comb begin
      cls = ClNop;
      case (opcode)
         5'b00000: cls = ClLd;
         5'b00001: cls = ClLdi;
         5'b00010: cls = ClSt;
         5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
         5'b01000, 5'b01001, 5'b01010, 5'b01011: cls = ClAlu;
         5'b01100, 5'b01101, 5'b01110: cls = ClImm;
`ifdef SEQ_MULDIV_EN
         5'b01111, 5'b10000: cls = ClMulDiv;
`endif
         5'b10001, 5'b10010: cls = ClUnary;
         5'b10011: cls = ClBrx;
         5'b10100: cls = ClJr;
         5'b10110: cls = ClIn;
         5'b10111: cls = ClOut;
         5'b11000: cls = ClMfhi;
         5'b11001: cls = ClMflo;
         5'b11011: cls = ClHalt;
         default:  cls = ClNop;
      endcase
   end

   always_comb begin
      case (opcode)
         5'b01101: imm_sel = 5'b00101;
         5'b01110: imm_sel = 5'b00110;
         default:  imm_sel = 5'b00011;
      endcase
   end

   // Final execute step of each class; run is sampled only there.
   always_comb begin
      case (cls)
         ClAlu, ClImm, ClLdi:              last_step = StT5;
         ClUnary:                          last_step = StT4;
         ClLd, ClSt:                       last_step = StT7;
         ClMulDiv, ClBrx:                  last_step = StT6;
         ClJr, ClIn, ClOut, ClMfhi, ClMflo: last_step = StT3;
         default:                          last_step = StT2;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (run) state_d = StT0;
         StT0:   state_d = StT1;
         StT1:   state_d = StT2;
         StT2: begin
            if (cls == ClHalt)     state_d = StHalt;
            else if (cls == ClNop) state_d = StT0;
            else                   state_d = StT3;
         end
         StT3, StT4, StT5, StT6, StT7: begin
            if (state_q == last_step) state_d = run ? StT0 : StIdle;
            else                      state_d = state_q + 4'd1;
         end
         StHalt: state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state_q <= StIdle;
      else      state_q <= state_d;
   end

   assign step   = state_q;
   assign halted = (state_q == StHalt);

   always_comb begin
      PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zin = 1'b0; ZLowout = 1'b0;
      ZHighout = 1'b0; PCin = 1'b0; MDRread = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
      IRin = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
      BAout = 1'b0; Yin = 1'b0; Cout = 1'b0; HIin = 1'b0; LOin = 1'b0;
      HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; OPin = 1'b0;
      CON_FF_In = 1'b0; wren = 1'b0; ALUSelection = 5'b00000;
      case (state_q)
         StT0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
         StT1: begin ZLowout = 1'b1; PCin = 1'b1; MDRread = 1'b1; MDRin = 1'b1; end
         StT2: begin MDRout = 1'b1; IRin = 1'b1; end
         StT3: begin
            case (cls)
               ClAlu, ClImm: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               ClLd, ClLdi, ClSt: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
               ClUnary: begin
                  Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUSelection = opcode;
               end
`ifdef SEQ_MULDIV_EN
               ClMulDiv: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
`endif
               ClBrx:  begin Gra = 1'b1; Rout = 1'b1; CON_FF_In = 1'b1; end
               ClJr:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
               ClIn:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               ClOut:  begin Gra = 1'b1; Rout = 1'b1; OPin = 1'b1; end
               ClMfhi: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               ClMflo: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               default: ;
            endcase
         end
         StT4: begin
            case (cls)
               ClAlu: begin
                  Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUSelection = opcode;
               end
               ClImm: begin Cout = 1'b1; Zin = 1'b1; ALUSelection = imm_sel; end
               ClLd, ClLdi, ClSt: begin Cout = 1'b1; Zin = 1'b1; ALUSelection = ADD_SEL; end
               ClUnary: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
`ifdef SEQ_MULDIV_EN
               ClMulDiv: begin
                  Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUSelection = opcode;
               end
`endif
               ClBrx: begin PCout = 1'b1; Yin = 1'b1; end
               default: ;
            endcase
         end
         StT5: begin
            case (cls)
               ClAlu, ClImm, ClLdi: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               ClLd, ClSt: begin ZLowout = 1'b1; MARin = 1'b1; end
`ifdef SEQ_MULDIV_EN
               ClMulDiv: begin ZLowout = 1'b1; LOin = 1'b1; end
`endif
               ClBrx: begin Cout = 1'b1; Zin = 1'b1; ALUSelection = ADD_SEL; end
               default: ;
            endcase
         end
         StT6: begin
            case (cls)
               ClLd: begin MDRread = 1'b1; MDRin = 1'b1; end
               // Store loads MDR from the register file, not memory.
               ClSt: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
`ifdef SEQ_MULDIV_EN
               ClMulDiv: begin ZHighout = 1'b1; HIin = 1'b1; end
`endif
               ClBrx: begin
                  if (CON_FF_Out) begin ZLowout = 1'b1; PCin = 1'b1; end
               end
               default: ;
            endcase
         end
         StT7: begin
            case (cls)
               ClLd: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               ClSt: wren = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios followed by
// random instruction streams, compared cycle by cycle against an
// instruction-level model that lists each instruction's strobe words.

module tb_control_sequencer;

   typedef logic [32:0] word_t;  // {halted, ALUSelection, strobes[26:0]}

`ifdef SEQ_MULDIV_EN
   localparam bit MulDivEn = 1'b1;
`else
   localparam bit MulDivEn = 1'b0;
`endif

   localparam logic [26:0] M_PCOUT  = 27'h1 << 0;
   localparam logic [26:0] M_MARIN  = 27'h1 << 1;
   localparam logic [26:0] M_INCPC  = 27'h1 << 2;
   localparam logic [26:0] M_ZIN    = 27'h1 << 3;
   localparam logic [26:0] M_ZLOW   = 27'h1 << 4;
   localparam logic [26:0] M_ZHIGH  = 27'h1 << 5;
   localparam logic [26:0] M_PCIN   = 27'h1 << 6;
   localparam logic [26:0] M_MDRRD  = 27'h1 << 7;
   localparam logic [26:0] M_MDRIN  = 27'h1 << 8;
   localparam logic [26:0] M_MDROUT = 27'h1 << 9;
   localparam logic [26:0] M_IRIN   = 27'h1 << 10;
   localparam logic [26:0] M_GRA    = 27'h1 << 11;
   localparam logic [26:0] M_GRB    = 27'h1 << 12;
   localparam logic [26:0] M_GRC    = 27'h1 << 13;
   localparam logic [26:0] M_RIN    = 27'h1 << 14;
   localparam logic [26:0] M_ROUT   = 27'h1 << 15;
   localparam logic [26:0] M_BAOUT  = 27'h1 << 16;
   localparam logic [26:0] M_YIN    = 27'h1 << 17;
   localparam logic [26:0] M_COUT   = 27'h1 << 18;
   localparam logic [26:0] M_HIIN   = 27'h1 << 19;
   localparam logic [26:0] M_LOIN   = 27'h1 << 20;
   localparam logic [26:0] M_HIOUT  = 27'h1 << 21;
   localparam logic [26:0] M_LOOUT  = 27'h1 << 22;
   localparam logic [26:0] M_INPORT = 27'h1 << 23;
   localparam logic [26:0] M_OPIN   = 27'h1 << 24;
   localparam logic [26:0] M_CONIN  = 27'h1 << 25;
   localparam logic [26:0] M_WREN   = 27'h1 << 26;

   localparam word_t W_HALT = 33'h1_0000_0000;

   logic clk = 1'b0;
   logic clr, run, CON_FF_Out;
   logic [31:0] IR;
   logic PCout, MARin, IncPC, Zin, ZLowout, ZHighout, PCin, MDRread, MDRin, MDRout, IRin;
   logic Gra, Grb, Grc, Rin, Rout, BAout, Yin, Cout, HIin, LOin, HIout, LOout;
   logic InPortout, OPin, CON_FF_In, wren, halted;
   logic [4:0] ALUSelection;
   logic [3:0] step;

   always #5 clk = ~clk;

   control_sequencer dut (
      .clk(clk), .clr(clr), .run(run), .IR(IR), .CON_FF_Out(CON_FF_Out),
      .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .ZLowout(ZLowout),
      .ZHighout(ZHighout), .PCin(PCin), .MDRread(MDRread), .MDRin(MDRin),
      .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
      .Rout(Rout), .BAout(BAout), .Yin(Yin), .Cout(Cout), .HIin(HIin), .LOin(LOin),
      .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .OPin(OPin),
      .CON_FF_In(CON_FF_In), .wren(wren), .ALUSelection(ALUSelection),
      .halted(halted), .step(step)
   );

   logic [26:0] strobes;
   word_t       obs;
   assign strobes = {wren, CON_FF_In, OPin, InPortout, LOout, HIout, LOin, HIin, Cout, Yin,
                     BAout, Rout, Rin, Grc, Grb, Gra, IRin, MDRout, MDRin, MDRread, PCin,
                     ZHighout, ZLowout, Zin, IncPC, MARin, PCout};
   assign obs = {halted, ALUSelection, strobes};

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;
   word_t       exp_q[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic word_t mk(input logic [26:0] s, input logic [4:0] sel);
      return {1'b0, sel, s};
   endfunction

   // Expected output word for every step of one instruction, T0 onward.
   task automatic build_seq(input logic [4:0] op, input logic con);
      logic [4:0] isel;
      exp_q.delete();
      exp_q.push_back(mk(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0));
      exp_q.push_back(mk(M_ZLOW | M_PCIN | M_MDRRD | M_MDRIN, 5'd0));
      exp_q.push_back(mk(M_MDROUT | M_IRIN, 5'd0));
      if (op >= 5'd3 && op <= 5'd11) begin
         exp_q.push_back(mk(M_GRB | M_ROUT | M_YIN, 5'd0));
         exp_q.push_back(mk(M_GRC | M_ROUT | M_ZIN, op));
         exp_q.push_back(mk(M_ZLOW | M_GRA | M_RIN, 5'd0));
      end else if (op >= 5'd12 && op <= 5'd14) begin
         isel = (op == 5'd12) ? 5'd3 : ((op == 5'd13) ? 5'd5 : 5'd6);
         exp_q.push_back(mk(M_GRB | M_ROUT | M_YIN, 5'd0));
         exp_q.push_back(mk(M_COUT | M_ZIN, isel));
         exp_q.push_back(mk(M_ZLOW | M_GRA | M_RIN, 5'd0));
      end else if (op == 5'd17 || op == 5'd18) begin
         exp_q.push_back(mk(M_GRB | M_ROUT | M_ZIN, op));
         exp_q.push_back(mk(M_ZLOW | M_GRA | M_RIN, 5'd0));
      end else if (op <= 5'd2) begin
         exp_q.push_back(mk(M_GRB | M_BAOUT | M_YIN, 5'd0));
         exp_q.push_back(mk(M_COUT | M_ZIN, 5'd3));
         if (op == 5'd1) begin
            exp_q.push_back(mk(M_ZLOW | M_GRA | M_RIN, 5'd0));
         end else begin
            exp_q.push_back(mk(M_ZLOW | M_MARIN, 5'd0));
            if (op == 5'd0) begin
               exp_q.push_back(mk(M_MDRRD | M_MDRIN, 5'd0));
               exp_q.push_back(mk(M_MDROUT | M_GRA | M_RIN, 5'd0));
            end else begin
               exp_q.push_back(mk(M_GRA | M_ROUT | M_MDRIN, 5'd0));
               exp_q.push_back(mk(M_WREN, 5'd0));
            end
         end
      end else if (MulDivEn && (op == 5'd15 || op == 5'd16)) begin
         exp_q.push_back(mk(M_GRA | M_ROUT | M_YIN, 5'd0));
         exp_q.push_back(mk(M_GRB | M_ROUT | M_ZIN, op));
         exp_q.push_back(mk(M_ZLOW | M_LOIN, 5'd0));
         exp_q.push_back(mk(M_ZHIGH | M_HIIN, 5'd0));
      end else if (op == 5'd19) begin
         exp_q.push_back(mk(M_GRA | M_ROUT | M_CONIN, 5'd0));
         exp_q.push_back(mk(M_PCOUT | M_YIN, 5'd0));
         exp_q.push_back(mk(M_COUT | M_ZIN, 5'd3));
         exp_q.push_back(mk(con ? (M_ZLOW | M_PCIN) : 27'd0, 5'd0));
      end else if (op == 5'd20) exp_q.push_back(mk(M_GRA | M_ROUT | M_PCIN, 5'd0));
      else if (op == 5'd22) exp_q.push_back(mk(M_INPORT | M_GRA | M_RIN, 5'd0));
      else if (op == 5'd23) exp_q.push_back(mk(M_GRA | M_ROUT | M_OPIN, 5'd0));
      else if (op == 5'd24) exp_q.push_back(mk(M_HIOUT | M_GRA | M_RIN, 5'd0));
      else if (op == 5'd25) exp_q.push_back(mk(M_LOOUT | M_GRA | M_RIN, 5'd0));
   endtask

   // Entered shortly after the rising edge that starts T0. Returns with the
   // landing state already checked; landed_t0 tells the caller where it is.
   task automatic run_instr(input logic [31:0] ir, input logic con, input logic run_after,
                            input string tag, output logic landed_t0);
      logic [4:0] op;
      logic       eff_run;
      int         n;
      op = ir[31:27];
      IR = ir;
      CON_FF_Out = con;
      build_seq(op, con);
      n = exp_q.size();
      // A bare fetch (nop class) returns to T0 unconditionally.
      eff_run = (n == 3 && op != 5'd27) ? 1'b1 : run_after;
      for (int k = 0; k < n; k++) begin
         run = (k == n - 1) ? eff_run : 1'($urandom);
         #1;
         check_eq($sformatf("%s T%0d", tag, k), obs, exp_q[k]);
         check_eq($sformatf("%s excl T%0d", tag, k), {wren & MDRread, Rin & Rout}, 0);
         @(posedge clk);
         #1;
      end
      if (op == 5'd27) begin
         check_eq({tag, " halt"}, obs, W_HALT);
         landed_t0 = 1'b0;
      end else if (eff_run) begin
         check_eq({tag, " next T0"}, obs, mk(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0));
         landed_t0 = 1'b1;
      end else begin
         check_eq({tag, " idle"}, obs, 0);
         landed_t0 = 1'b0;
      end
   endtask

   task automatic idle_to_t0(input int idle_cycles);
      run = 1'b0;
      for (int i = 0; i < idle_cycles; i++) begin
         @(posedge clk);
         #1;
         check_eq("idle hold", obs, 0);
      end
      run = 1'b1;
      @(posedge clk);
      #1;
      check_eq("idle->T0", obs, mk(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic       at_t0;
      logic [4:0] op;
      clr = 1'b0; run = 1'b1; IR = 32'h0; CON_FF_Out = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset outputs", obs, 0);
      check_eq("reset step", step, 0);
      @(negedge clk);
      clr = 1'b1;
      #1;
      check_eq("post-reset idle", obs, 0);
      @(posedge clk);
      #1;
      check_eq("first T0", obs, mk(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0));

      // Reset during T4 of add aborts at once.
      IR = 32'h18000000;
      repeat (4) @(posedge clk);
      #1;
      check_eq("add T4 pre-abort", obs, mk(M_GRC | M_ROUT | M_ZIN, 5'd3));
      clr = 1'b0;
      #1;
      check_eq("abort outputs", obs, 0);
      check_eq("abort step", step, 0);
      @(negedge clk);
      clr = 1'b1;
      run = 1'b1;
      @(posedge clk);
      #1;
      check_eq("abort restart T0", obs, mk(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0));

      run_instr(32'h18000000, 1'b0, 1'b1, "add", at_t0);
      run_instr(32'h01000044, 1'b0, 1'b1, "ld", at_t0);
      run_instr(32'h10000000, 1'b0, 1'b1, "st", at_t0);
      run_instr(32'hC3000000, 1'b0, 1'b1, "mfhi", at_t0);
      run_instr(32'hC8000000, 1'b0, 1'b1, "mflo", at_t0);
      run_instr(32'h98000000, 1'b0, 1'b1, "brx c0", at_t0);
      run_instr(32'h98000000, 1'b1, 1'b1, "brx c1", at_t0);
      run_instr(32'h80000000, 1'b0, 1'b1, "mul", at_t0);
      run_instr(32'h78000000, 1'b0, 1'b0, "div", at_t0);
      if (!at_t0) idle_to_t0(2);

      for (int i = 0; i < 150; i++) begin
         do op = 5'($urandom_range(0, 31)); while (op == 5'd27);
         run_instr({op, 27'($urandom)}, 1'($urandom), ($urandom_range(0, 3) != 0),
                   $sformatf("rnd%0d op%0d", i, op), at_t0);
         if (!at_t0) idle_to_t0($urandom_range(0, 3));
      end

      run_instr(32'hD8000000, 1'b0, 1'b1, "halt", at_t0);
      for (int i = 0; i < 20; i++) begin
         run = 1'($urandom);
         @(posedge clk);
         #1;
         check_eq($sformatf("halt hold %0d", i), obs, W_HALT);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
